// File: rtl/font5x7_text_layer_if.sv
// Host-side bus of the text layer: character writes, clear request and clear status.
interface font5x7_text_layer_if;
  logic        WR_i;
  logic [11:0] WADRs_i;
  logic [7:0]  WDATs_i;
  logic        CLR_i;
  logic        BUSY_o;

  modport master (output WR_i, WADRs_i, WDATs_i, CLR_i, input BUSY_o);
  modport slave  (input WR_i, WADRs_i, WDATs_i, CLR_i, output BUSY_o);
endinterface

// File: rtl/font5x7_text_layer.sv
// 80x30 character-cell text renderer with 5x7 glyphs in 8x8 cells.
// Pixel output lags the timing counters by two enabled clocks. Each cell's
// glyph row is prefetched at dot 4 of the previous cell (or at the end of the
// previous line for column 0) and swapped in when the delayed dot count wraps.
//
// Clear FSM states:
//   state  | meaning
//   S_IDLE | host writes accepted, waiting for CLR_i
//   S_FILL | writing 0x20 to every cell, host writes and CLR_i dropped
module font5x7_text_layer #(
  parameter int C_H_PX_N    = 780,
  parameter int C_V_LINE_N  = 263,
  parameter int C_COLS      = 80,
  parameter int C_ROWS      = 30,
  parameter int C_BLINK_BIT = 5
) (
  input  logic        CK_i,
  input  logic        RST_i,
  input  logic        CK_EE_i,
  input  logic [9:0]  HCTRs_i,
  input  logic [8:0]  VCTRs_i,
  input  logic [7:0]  FCTRs_i,
  input  logic        XBLK_i,
  input  logic        CUR_EN_i,
  input  logic [11:0] CUR_ADRs_i,
  output logic [9:0]  FONT_ADRs_o,
  input  logic [4:0]  FONT_DATs_i,
  output logic        PX_o,
  font5x7_text_layer_if.slave host
);

  localparam int C_CELLS = C_COLS * C_ROWS;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  logic [7:0]  ram [0:C_CELLS-1];

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        we_w;
  logic [11:0] wa_w;
  logic [7:0]  wd_w;

  logic [6:0]  col_w;
  logic [4:0]  row_w;
  logic [11:0] cell_adr_w;
  logic        cur_hit_w;

  logic        wrap_w;
  logic [8:0]  v_nxt_w, tv_w;
  logic [7:0]  tcol_w;
  logic [4:0]  trow_w;
  logic [2:0]  tgl_w;
  logic        oor_w;
  logic [11:0] tadr_w, rd_idx_w;
  logic [7:0]  rd_dat_w;
  logic        fetch_w;

  logic [2:0]  dot_q, gline_q;
  logic        cur_q, xblk_q;
  logic [9:0]  font_adr_q;
  logic        f_vld_q, f_inv_q, f2_vld_q, f2_inv_q;
  logic [4:0]  nxt_gly_q, act_gly_q;
  logic        nxt_inv_q, act_inv_q;
  logic        px_q, px_d;
  logic [4:0]  gly_w;
  logic        inv_w, lit_w;
  logic [7:0]  row8_w;

  logic        unused_w;
  assign unused_w = ^{FCTRs_i, tv_w[8]};

  assign col_w      = HCTRs_i[9:3];
  assign row_w      = VCTRs_i[7:3];
  assign cell_adr_w = 12'(row_w) * 12'(C_COLS) + 12'(col_w);
  assign cur_hit_w  = CUR_EN_i && (cell_adr_w == CUR_ADRs_i) && FCTRs_i[C_BLINK_BIT];
  assign fetch_w    = (HCTRs_i[2:0] == 3'd4);

  // Locate the cell whose glyph row is prefetched: next column, or column 0 of the next line.
  always_comb begin
    wrap_w   = (HCTRs_i >= 10'(C_H_PX_N - 8));
    v_nxt_w  = (VCTRs_i == 9'(C_V_LINE_N - 1)) ? 9'd0 : VCTRs_i + 9'd1;
    tv_w     = wrap_w ? v_nxt_w : VCTRs_i;
    tcol_w   = wrap_w ? 8'd0 : {1'b0, col_w} + 8'd1;
    trow_w   = tv_w[7:3];
    tgl_w    = tv_w[2:0];
    oor_w    = (tcol_w >= 8'(C_COLS)) || (trow_w >= 5'(C_ROWS));
    tadr_w   = 12'(trow_w) * 12'(C_COLS) + 12'(tcol_w);
    rd_idx_w = oor_w ? 12'd0 : tadr_w;
  end

  // Asynchronous read: a same-cycle write lands at the edge, so the read sees old data.
  assign rd_dat_w = ram[rd_idx_w];

  // Clear FSM next state and text RAM write source selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_w    = 1'b0;
    wa_w    = host.WADRs_i;
    wd_w    = host.WDATs_i;
    unique case (state_q)
      S_IDLE: begin
        if (host.CLR_i) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
        if (host.WR_i && (host.WADRs_i < 12'(C_CELLS))) we_w = 1'b1;
      end
      S_FILL: begin
        we_w = 1'b1;
        wa_w = cnt_q;
        wd_w = 8'h20;
        if (cnt_q == 12'(C_CELLS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear FSM state and fill address.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (CK_EE_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Text RAM write port; contents survive reset, but no write lands on a reset edge.
  always_ff @(posedge CK_i) begin
    if (!RST_i && CK_EE_i && we_w) ram[wa_w] <= wd_w;
  end

  // Glyph of the cell being drawn: the freshly fetched one on dot 0, else the held copy.
  always_comb begin
    gly_w  = (dot_q == 3'd0) ? nxt_gly_q : act_gly_q;
    inv_w  = (dot_q == 3'd0) ? nxt_inv_q : act_inv_q;
    row8_w = {gly_w, 3'b000};
    lit_w  = (gline_q != 3'd7) && row8_w[~dot_q];
    px_d   = (lit_w ^ inv_w ^ cur_q) & xblk_q;
  end

  // Pixel pipeline (counters -> stage 1 -> PX) and glyph prefetch pipeline.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      dot_q      <= '0;
      gline_q    <= '0;
      cur_q      <= 1'b0;
      xblk_q     <= 1'b0;
      font_adr_q <= '0;
      f_vld_q    <= 1'b0;
      f_inv_q    <= 1'b0;
      f2_vld_q   <= 1'b0;
      f2_inv_q   <= 1'b0;
      nxt_gly_q  <= '0;
      nxt_inv_q  <= 1'b0;
      act_gly_q  <= '0;
      act_inv_q  <= 1'b0;
      px_q       <= 1'b0;
    end else if (CK_EE_i) begin
      dot_q   <= HCTRs_i[2:0];
      gline_q <= VCTRs_i[2:0];
      cur_q   <= cur_hit_w;
      xblk_q  <= XBLK_i;
      f_vld_q <= fetch_w;
      if (fetch_w) begin
        font_adr_q <= oor_w ? {7'd0, tgl_w} : {rd_dat_w[6:0], tgl_w};
        f_inv_q    <= oor_w ? 1'b0 : rd_dat_w[7];
      end
      f2_vld_q <= f_vld_q;
      f2_inv_q <= f_inv_q;
      if (f2_vld_q) begin
        nxt_gly_q <= FONT_DATs_i;
        nxt_inv_q <= f2_inv_q;
      end
      if (dot_q == 3'd0) begin
        act_gly_q <= nxt_gly_q;
        act_inv_q <= nxt_inv_q;
      end
      px_q <= px_d;
    end
  end

  assign FONT_ADRs_o = font_adr_q;
  assign PX_o        = px_q;
  assign host.BUSY_o = (state_q == S_FILL);

endmodule

// File: tb/tb_font5x7_text_layer.sv
// Directed bench for font5x7_text_layer with a queue-based scoreboard.
module tb_font5x7_text_layer;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [9:0]  h = '0;
  logic [8:0]  v = '0;
  logic [7:0]  f = '0;
  logic        xblk = 1'b0;
  logic        cur_en = 1'b0;
  logic [11:0] cur_adr = '0;
  logic [9:0]  font_adr;
  logic [4:0]  font_dat = '0;
  logic        px;
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;

  font5x7_text_layer_if hif ();

  font5x7_text_layer dut (
    .CK_i        (ck),
    .RST_i       (rst),
    .CK_EE_i     (ce),
    .HCTRs_i     (h),
    .VCTRs_i     (v),
    .FCTRs_i     (f),
    .XBLK_i      (xblk),
    .CUR_EN_i    (cur_en),
    .CUR_ADRs_i  (cur_adr),
    .FONT_ADRs_o (font_adr),
    .FONT_DATs_i (font_dat),
    .PX_o        (px),
    .host        (hif)
  );

  always #5 ck = ~ck;

  always @(posedge ck) cyc <= cyc + 1;

  // Font ROM model: 'A' line 0 = 01110, other 'A' lines = 10001, every other glyph blank.
  function automatic logic [4:0] font_fn(input logic [9:0] a);
    if (a == {7'h41, 3'd0}) return 5'b01110;
    if (a[9:3] == 7'h41) return 5'b10001;
    return 5'b00000;
  endfunction

  always @(posedge ck) if (ce) font_dat <= font_fn(font_adr);

  typedef struct {
    int         due;
    int         kind;
    int         tag;
    logic [9:0] exp;
  } sb_t;

  sb_t sbq[$];

  task automatic push(input int due, input int kind, input int tag, input logic [9:0] exp);
    sb_t e;
    e.due = due; e.kind = kind; e.tag = tag; e.exp = exp;
    sbq.push_back(e);
  endtask

  // Monitor: compare every scoreboard entry that falls due on this cycle.
  initial begin
    logic [9:0] act;
    string      nm;
    forever begin
      @(negedge ck);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].due <= cyc) begin
          case (sbq[i].kind)
            0:       begin act = {9'd0, px};         nm = "px"; end
            1:       begin act = font_adr;           nm = "font_adr"; end
            default: begin act = {9'd0, hif.BUSY_o}; nm = "busy"; end
          endcase
          n_run++;
          if (sbq[i].due < cyc || act !== sbq[i].exp) begin
            n_fail++;
            $display("FAIL %s #%0d cyc=%0d got %h want %h", nm, sbq[i].tag, cyc, act, sbq[i].exp);
          end
          sbq.delete(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    hif.WR_i = 1'b1; hif.WADRs_i = 12'(a); hif.WDATs_i = d;
    tick();
    hif.WR_i = 1'b0;
  endtask

  // Drive n consecutive dots of line vv from h0; expv[7-i] is the pixel expected for dot i.
  task automatic run_px(input int vv, input int h0, input int n, input logic xb,
                        input logic [7:0] expv, input bit chk, input int tag);
    for (int i = 0; i < n; i++) begin
      h = 10'(h0 + i); v = 9'(vv); xblk = xb;
      if (chk) push(cyc + 2, 0, tag * 10 + i, {9'd0, expv[7 - i]});
      tick();
    end
  endtask

  task automatic chk_font(input int hh, input int vv, input logic [9:0] exp, input int tag);
    h = 10'(hh); v = 9'(vv);
    push(cyc + 1, 1, tag, exp);
    tick();
  endtask

  // Read back cells a0..a1 through the prefetch address, expecting character ch on line 0.
  task automatic scan(input int a0, input int a1, input logic [6:0] ch);
    int r, c;
    for (int a = a0; a <= a1; a++) begin
      r = a / 80; c = a % 80;
      if (c == 0) chk_font(772, (r == 0) ? 262 : r * 8 - 1, {ch, 3'd0}, a);
      else        chk_font((c - 1) * 8 + 4, r * 8, {ch, 3'd0}, a);
    end
  endtask

  initial begin
    int k0;
    hif.WR_i = 1'b0; hif.WADRs_i = '0; hif.WDATs_i = '0; hif.CLR_i = 1'b0;
    tick();
    // Reset state, with a prefetch position on the counters.
    rst = 1'b1; h = 10'd4; xblk = 1'b1;
    push(cyc + 1, 0, 1, 10'd0);
    push(cyc + 1, 1, 1, 10'd0);
    push(cyc + 1, 2, 1, 10'd0);
    tick(); tick();
    rst = 1'b0; h = '0; xblk = 1'b0;
    tick();

    // Full clear at CK_EE=1; a dropped write and an ignored CLR during the fill.
    k0 = cyc;
    hif.CLR_i = 1'b1;
    push(k0 + 1, 2, 2, 10'd1);
    push(k0 + 2400, 2, 3, 10'd1);
    push(k0 + 2401, 2, 4, 10'd0);
    tick();
    hif.CLR_i = 1'b0;
    while (cyc < k0 + 2405) begin
      hif.WR_i  = (cyc == k0 + 100);
      hif.CLR_i = (cyc == k0 + 500);
      hif.WADRs_i = 12'd10; hif.WDATs_i = 8'h55;
      tick();
    end
    hif.WR_i = 1'b0; hif.CLR_i = 1'b0;
    scan(0, 2399, 7'h20);

    // 'A' in cell 0, line 0.
    wr(0, 8'h41);
    xblk = 1'b1;
    run_px(262, 772, 8, 1'b1, 8'h00, 1'b0, 0);
    run_px(0, 0, 8, 1'b1, 8'b0111_0000, 1'b1, 100);

    // Line/frame wrap and out-of-range prefetch targets.
    wr(80, 8'h52);
    chk_font(772, 7, {7'h52, 3'd0}, 5000);
    chk_font(772, 262, {7'h41, 3'd0}, 5001);
    chk_font(636, 10, 10'd2, 5002);
    chk_font(4, 240, 10'd0, 5003);

    // Inverse 'A' in cell 81: line 7 fully lit, line 2 inverted glyph, blanked by XBLK.
    wr(81, 8'hC1);
    run_px(15, 0, 8, 1'b1, 8'h00, 1'b0, 0);
    run_px(15, 8, 8, 1'b1, 8'hFF, 1'b1, 200);
    run_px(10, 0, 8, 1'b1, 8'h00, 1'b0, 0);
    run_px(10, 8, 8, 1'b1, 8'b0111_0111, 1'b1, 210);
    run_px(15, 0, 8, 1'b0, 8'h00, 1'b0, 0);
    run_px(15, 8, 8, 1'b0, 8'h00, 1'b1, 220);

    // Blinking cursor on blank cell 0.
    wr(0, 8'h20);
    cur_en = 1'b1; cur_adr = 12'd0;
    for (int ph = 0; ph < 2; ph++) begin
      f = (ph == 0) ? 8'h00 : 8'h20;
      for (int vv = 0; vv < 8; vv++) begin
        run_px((vv == 0) ? 262 : vv - 1, 772, 8, 1'b1, 8'h00, 1'b0, 0);
        run_px(vv, 0, 8, 1'b1, (ph == 0) ? 8'h00 : 8'hFF, 1'b1, 300 + ph * 10 + vv);
      end
    end
    cur_en = 1'b0; f = 8'h00;

    // Same-cycle read and write of cell 5 returns the old data.
    hif.WR_i = 1'b1; hif.WADRs_i = 12'd5; hif.WDATs_i = 8'h77;
    chk_font(36, 0, {7'h20, 3'd0}, 6000);
    hif.WR_i = 1'b0;
    chk_font(36, 0, {7'h77, 3'd0}, 6001);

    // Clear at 50% clock-enable duty.
    wr(2399, 8'h41);
    h = '0; v = '0;
    k0 = cyc;
    hif.CLR_i = 1'b1;
    push(k0 + 1, 2, 5, 10'd1);
    push(k0 + 4800, 2, 6, 10'd1);
    push(k0 + 4801, 2, 7, 10'd0);
    tick();
    hif.CLR_i = 1'b0;
    while (cyc < k0 + 4805) begin
      ce = ((cyc - k0) % 2 == 0);
      tick();
    end
    ce = 1'b1;
    scan(0, 0, 7'h20);
    scan(5, 5, 7'h20);
    scan(80, 81, 7'h20);
    scan(2399, 2399, 7'h20);

    // Reset while the fill is at address 1000.
    wr(999, 8'h41);
    wr(1500, 8'h33);
    h = '0; v = '0;
    k0 = cyc;
    hif.CLR_i = 1'b1;
    push(k0 + 1001, 2, 8, 10'd1);
    push(k0 + 1002, 2, 9, 10'd0);
    tick();
    hif.CLR_i = 1'b0;
    while (cyc < k0 + 1004) begin
      rst = (cyc == k0 + 1001);
      tick();
    end
    rst = 1'b0;
    tick();
    scan(998, 999, 7'h20);
    scan(1500, 1500, 7'h33);

    repeat (5) tick();
    if (sbq.size() != 0) begin
      $display("FAIL drain %0d entries never compared", sbq.size());
      n_fail += sbq.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/font5x7_text_layer.md
Name: font5x7_text_layer

Overview:
- Character-cell text renderer directly downstream of the NTSC square-pixel timing generator.
- Consumes HCTRs/VCTRs/FCTRs/XBLK and produces a 1-bit luminance pixel. The pixel lags the counters by exactly 2 clocks, which matches the generator's C_PX_DLY = 2.
- Holds an 80x30 text RAM (cell 8x8, glyph 5x7 top-left) with a host write port and a hardware clear engine.
- Reads glyph rows from an external 1-cycle-latency font ROM. Supports an inverse-video attribute and a blinking block cursor.

Parameters:
C_H_PX_N, 780, total clocks per line (HCTR wraps C_H_PX_N-1 -> 0)
C_V_LINE_N, 263, total lines per frame (VCTR wraps C_V_LINE_N-1 -> 0)
C_COLS, 80, text columns (640/8)
C_ROWS, 30, text rows (240/8)
C_BLINK_BIT, 5, FCTRs bit driving cursor blink (about 0.94 Hz at 59.94 fps)

Ports:
CK_i  in  1  system clock, 12.27272 MHz
RST_i  in  1  synchronous reset, active-high
CK_EE_i  in  1  clock enable; all state holds when low
HCTRs_i  in  10  horizontal counter from timing generator
VCTRs_i  in  9  vertical counter
FCTRs_i  in  8  frame counter
XBLK_i  in  1  active-video flag, high = visible
WR_i  in  1  host write strobe, single cycle
WADRs_i  in  12  host write address, row*80+col, valid 0..2399
WDATs_i  in  8  host write data; [6:0] char code, [7] inverse
CLR_i  in  1  start clear-screen fill
CUR_EN_i  in  1  cursor enable
CUR_ADRs_i  in  12  cursor cell address
FONT_ADRs_o  out  10  font ROM address {char[6:0], glyph_line[2:0]}
FONT_DATs_i  in  5  font ROM data, valid 1 clock after address; bit4 = leftmost dot
BUSY_o  out  1  clear engine active
PX_o  out  1  pixel, 1 = white; aligned to counters +2 clocks

Behaviour:
- Reset: PX_o=0, BUSY_o=0, FONT_ADRs_o=0, pipeline and glyph buffers=0, clear FSM IDLE. Text RAM contents are not reset.
- All registers advance only when CK_EE_i=1. RST_i has priority over CK_EE_i.
- Pixel mapping for counters (h, v):
  - col = h[9:3], row = v[7:3], dot = h[2:0], gline = v[2:0].
  - Pixel is lit iff dot<5, gline<7, and the glyph bit (4-dot) is set.
  - The result is XORed with the inverse bit, then XORed with the cursor term.
  - Cursor term: CUR_EN_i & (row*80+col == CUR_ADRs_i) & FCTRs_i[C_BLINK_BIT]; covers the whole 8x8 cell.
  - The result is ANDed with XBLK_i. All terms are delayed 2 clocks so PX_o(t+2) = f(inputs at t).
- Prefetch for the next cell:
  - Issued when h[2:0]==4.
  - Target cell: col+1 on the same line. When h >= C_H_PX_N-8, target is col 0 of line v+1 (wrapping C_V_LINE_N-1 -> 0).
  - Cycle P: text RAM read.
  - P+1: FONT_ADRs_o driven.
  - P+2: FONT_DATs_i and inverse bit latched into the next-cell buffer.
  - The next-cell buffer is copied to the active shifter when the delayed dot counter wraps to 0.
- Out-of-range targets (col >= C_COLS or row >= C_ROWS): fetch result forced to blank (char 0, inverse 0).
- Text RAM: 2400x8, one write port and one read port.
  - On a same-cycle read/write to the same address, the read returns the old data.
  - WR_i with WADRs_i >= 2400 is ignored.
- Clear FSM:
  - States: IDLE, FILL.
  - IDLE -> FILL on CLR_i. Address counter starts at 0 and writes 0x20 each enabled clock.
  - FILL -> IDLE after writing address 2399 (2400 enabled clocks).
  - BUSY_o=1 throughout FILL, registered, asserted the cycle after CLR_i.
  - During FILL, WR_i is ignored and CLR_i is ignored.
  - Reading for display continues during FILL.
- Reset mid-FILL returns the FSM to IDLE with BUSY_o=0. The partially cleared RAM is left as is.
- Inverse cells also invert the gap dots and line 7, giving a full 8x8 inverted cell.

Test Plan:
- Write 0x41 to address 0; font model returns 5'b01110 for {0x41, line 0}; counters at h=0..7, v=0 -> PX_o at t+2 = 0,1,1,1,0,0,0,0.
- Write 0xC1 (inverse 'A') to address 81, drive v=15 (row 1, gline 7) -> PX_o = 1 for h=8..15, 2 clocks later; XBLK_i=0 at the same point -> PX_o = 0.
- Set CUR_EN_i=1, CUR_ADRs_i=0; blank cell; FCTRs bit5 toggled 0 then 1 -> PX_o all 0, then all 1 over h=0..7, v=0..7.
- Line wrap: at h=772, v=7 -> FONT_ADRs_o shows {char at addr 80, line 0}; at v=262, h=772 -> {char at addr 0, line 0}.
- Pulse CLR_i -> BUSY_o high for exactly 2400 clocks. A WR_i of 0x55 during FILL is dropped. Afterwards every address reads 0x20. Repeat with CK_EE_i at 50% duty -> 4800 clocks.
- Assert RST_i at fill count 1000 -> BUSY_o=0 next clock. Address 999 = 0x20; address 1500 keeps its prior value.
